// File: rtl/write_burst_scheduler_pkg.sv
// Shared definitions for the VDMA write-side burst scheduler.
// Holds the scheduler FSM encoding, the MODE selector constants and a
// ceiling-divide helper used by the burst length arithmetic.
package write_burst_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CALC       = 3'd1,
    WAIT_DATA  = 3'd2,
    REQ        = 3'd3,
    WAIT_DONE  = 3'd4,
    FRAME_END  = 3'd5
  } sched_state_e;

  // "ONCE": the whole frame is one transfer; "LINE": every line is a transfer.
  localparam logic [31:0] MODE_ONCE = "ONCE";
  localparam logic [31:0] MODE_LINE = "LINE";

  // ceil(num / den); den must be non-zero.
  function automatic logic [31:0] ceil_div(input logic [63:0] num, input logic [31:0] den);
    logic [63:0] q;
    q = (num + 64'(den) - 64'd1) / 64'(den);
    return q[31:0];
  endfunction

endpackage

// File: rtl/write_burst_scheduler_if.sv
// Burst command channel between the scheduler and the AXI write master.
//   burst_req  : command valid            (scheduler -> master)
//   burst_len  : beats in the command     (scheduler -> master)
//   burst_addr : byte start address       (scheduler -> master)
//   burst_tail : last burst of a transfer (scheduler -> master)
//   burst_ack  : command accepted         (master -> scheduler)
//   burst_done : last accepted burst done (master -> scheduler)
interface write_burst_scheduler_if #(
  parameter int LSIZE = 9,
  parameter int ASIZE = 32
) ();

  logic             burst_req;
  logic             burst_ack;
  logic [LSIZE-1:0] burst_len;
  logic [ASIZE-1:0] burst_addr;
  logic             burst_tail;
  logic             burst_done;

  modport master (
    output burst_req, burst_len, burst_addr, burst_tail,
    input  burst_ack, burst_done
  );

  modport slave (
    input  burst_req, burst_len, burst_addr, burst_tail,
    output burst_ack, burst_done
  );

endinterface

// File: rtl/write_burst_scheduler_burst_len_calc.sv
// burst_len_calc: two-stage registered arithmetic turning a frame geometry
// into per-transfer burst counts. Shared by the read and write schedulers.
//   clock, rst            : clock, synchronous active-high reset
//   ld_pixels             : stage 1 load (pixels per transfer, transfer count)
//   ld_beats              : stage 2 load (full bursts and remainder beats)
//   hactive, vactive      : pixels per line, lines per frame
//   is_zero               : nothing to move (valid after stage 1)
//   transfers             : transfers per frame
//   full_bursts, rem_beats: bursts of NOR_BURST_LEN and the tail remainder
module burst_len_calc
  import write_burst_scheduler_pkg::*;
#(
  parameter int NOR_BURST_LEN = 200,
  parameter int AXI_DSIZE     = 256,
  parameter int DSIZE         = 24,
  parameter bit LINE_MODE     = 1'b0
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        ld_pixels,
  input  logic        ld_beats,
  input  logic [15:0] hactive,
  input  logic [15:0] vactive,
  output logic        is_zero,
  output logic [15:0] transfers,
  output logic [31:0] full_bursts,
  output logic [31:0] rem_beats
);

  logic [31:0] pixels_r;
  logic [15:0] transfers_r;
  logic [31:0] full_r;
  logic [31:0] rem_r;
  logic [31:0] beats_s;

  // AXI beats per transfer from the stage-1 pixel count (64-bit bit count avoids overflow)
  always_comb begin
    beats_s = ceil_div(64'(pixels_r) * 64'(DSIZE), 32'(AXI_DSIZE));
  end

  // Stage 1: pixels per transfer (32-bit product) and transfers per frame
  always_ff @(posedge clock) begin
    if (rst) begin
      pixels_r    <= 32'd0;
      transfers_r <= 16'd0;
    end else if (ld_pixels) begin
      pixels_r    <= LINE_MODE ? {16'd0, hactive} : (32'(hactive) * 32'(vactive));
      transfers_r <= LINE_MODE ? vactive : 16'd1;
    end
  end

  // Stage 2: split the beat count into full bursts plus a remainder
  always_ff @(posedge clock) begin
    if (rst) begin
      full_r <= 32'd0;
      rem_r  <= 32'd0;
    end else if (ld_beats) begin
      full_r <= beats_s / 32'(NOR_BURST_LEN);
      rem_r  <= beats_s % 32'(NOR_BURST_LEN);
    end
  end

  // With DSIZE > 0, zero pixels means zero beats, so stage 1 already decides this
  assign is_zero     = (pixels_r == 32'd0) || (transfers_r == 16'd0);
  assign transfers   = transfers_r;
  assign full_bursts = full_r;
  assign rem_beats   = rem_r;

endmodule

// File: rtl/write_burst_scheduler.sv
// write_burst_scheduler: splits a video frame into AXI write burst commands.
//   clock, rst            : clock, synchronous active-high reset
//   vactive, hactive      : frame geometry, sampled in CALC
//   base_addr             : frame start byte address, sampled in CALC
//   fsync                 : one-cycle frame start
//   fifo_count            : AXI words waiting in the write FIFO
//   bus                   : burst command channel (master side)
//   frame_done            : one-cycle pulse after the frame's last burst
//   busy                  : high whenever the FSM is not IDLE
module write_burst_scheduler
  import write_burst_scheduler_pkg::*;
#(
  parameter int          NOR_BURST_LEN = 200,
  parameter logic [31:0] MODE          = MODE_ONCE,
  parameter int          AXI_DSIZE     = 256,
  parameter int          DSIZE         = 24,
  parameter int          LSIZE         = 9,
  parameter int          ASIZE         = 32
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [15:0]       vactive,
  input  logic [15:0]       hactive,
  input  logic [ASIZE-1:0]  base_addr,
  input  logic              fsync,
  input  logic [15:0]       fifo_count,
  write_burst_scheduler_if.master bus,
  output logic              frame_done,
  output logic              busy
);

  localparam bit LINE_MODE_C      = (MODE == MODE_LINE);
  localparam int BYTES_PER_BEAT_C = AXI_DSIZE / 8;

  sched_state_e     state_r, state_next_s;
  logic             calc_cnt_r;
  logic             fsync_pend_r;
  logic [31:0]      burst_idx_r;
  logic [15:0]      xfer_idx_r;
  logic             ld_pixels_s, ld_beats_s;
  logic             calc_zero_s;
  logic [15:0]      transfers_s;
  logic [31:0]      full_s, rem_s, total_s;
  logic [LSIZE-1:0] pend_len_s;
  logic             pend_tail_s;
  logic             last_frame_burst_s;
  logic             burst_req_r, burst_tail_r, frame_done_r, busy_r;
  logic [LSIZE-1:0] burst_len_r;
  logic [ASIZE-1:0] burst_addr_r;

  assign ld_pixels_s = (state_r == CALC) && !calc_cnt_r;
  assign ld_beats_s  = (state_r == CALC) &&  calc_cnt_r;

  burst_len_calc #(
    .NOR_BURST_LEN (NOR_BURST_LEN),
    .AXI_DSIZE     (AXI_DSIZE),
    .DSIZE         (DSIZE),
    .LINE_MODE     (LINE_MODE_C)
  ) u_calc (
    .clock       (clock),
    .rst         (rst),
    .ld_pixels   (ld_pixels_s),
    .ld_beats    (ld_beats_s),
    .hactive     (hactive),
    .vactive     (vactive),
    .is_zero     (calc_zero_s),
    .transfers   (transfers_s),
    .full_bursts (full_s),
    .rem_beats   (rem_s)
  );

  assign total_s            = full_s + ((rem_s != 32'd0) ? 32'd1 : 32'd0);
  assign last_frame_burst_s = burst_tail_r && (xfer_idx_r == (transfers_s - 16'd1));

  // Length and tail flag of the next burst within the current transfer
  always_comb begin
    pend_len_s  = LSIZE'(NOR_BURST_LEN);
    pend_tail_s = 1'b0;
    if (burst_idx_r < full_s) begin
      pend_len_s = LSIZE'(NOR_BURST_LEN);
    end else begin
      pend_len_s = LSIZE'(rem_s);
    end
    if ((burst_idx_r + 32'd1) == total_s) begin
      pend_tail_s = 1'b1;
    end else begin
      pend_tail_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (fsync) state_next_s = CALC;
        else       state_next_s = IDLE;
      end
      CALC: begin
        if (fsync)            state_next_s = CALC;
        else if (!calc_cnt_r) state_next_s = CALC;
        else if (calc_zero_s) state_next_s = FRAME_END;
        else                  state_next_s = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (fsync)                                      state_next_s = CALC;
        else if (32'(fifo_count) >= 32'(pend_len_s))    state_next_s = REQ;
        else                                            state_next_s = WAIT_DATA;
      end
      REQ: begin
        // burst_done is deliberately not looked at here
        if (bus.burst_ack) state_next_s = WAIT_DONE;
        else               state_next_s = REQ;
      end
      WAIT_DONE: begin
        if (!bus.burst_done)              state_next_s = WAIT_DONE;
        else if (fsync_pend_r || fsync)   state_next_s = CALC;
        else if (last_frame_burst_s)      state_next_s = FRAME_END;
        else                              state_next_s = WAIT_DATA;
      end
      FRAME_END: state_next_s = IDLE;
      default:   state_next_s = IDLE;
    endcase
  end

  // CALC phase counter: 0 on entry or restart, 1 in the second cycle
  always_ff @(posedge clock) begin
    if (rst) begin
      calc_cnt_r <= 1'b0;
    end else begin
      calc_cnt_r <= (state_r == CALC) && !fsync && (state_next_s == CALC);
    end
  end

  // Remember an fsync that lands while a burst is outstanding
  always_ff @(posedge clock) begin
    if (rst) begin
      fsync_pend_r <= 1'b0;
    end else if (state_next_s == CALC) begin
      fsync_pend_r <= 1'b0;
    end else if (fsync && ((state_r == REQ) || (state_r == WAIT_DONE))) begin
      fsync_pend_r <= 1'b1;
    end
  end

  // Burst-within-transfer and transfer-within-frame counters
  always_ff @(posedge clock) begin
    if (rst) begin
      burst_idx_r <= 32'd0;
      xfer_idx_r  <= 16'd0;
    end else if (state_r == CALC) begin
      burst_idx_r <= 32'd0;
      xfer_idx_r  <= 16'd0;
    end else if ((state_r == WAIT_DONE) && bus.burst_done) begin
      if (burst_tail_r) begin
        burst_idx_r <= 32'd0;
        xfer_idx_r  <= xfer_idx_r + 16'd1;
      end else begin
        burst_idx_r <= burst_idx_r + 32'd1;
      end
    end
  end

  // Registered command channel and status outputs
  always_ff @(posedge clock) begin
    if (rst) begin
      burst_req_r  <= 1'b0;
      burst_len_r  <= '0;
      burst_addr_r <= '0;
      burst_tail_r <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      burst_req_r  <= (state_next_s == REQ);
      frame_done_r <= (state_next_s == FRAME_END);
      busy_r       <= (state_next_s != IDLE);
      if ((state_r == WAIT_DATA) && (state_next_s == REQ)) begin
        burst_len_r  <= pend_len_s;
        burst_tail_r <= pend_tail_s;
      end
      // Addresses run contiguously across lines; only a new frame reloads the base
      if (ld_pixels_s) begin
        burst_addr_r <= base_addr;
      end else if ((state_r == WAIT_DONE) && bus.burst_done) begin
        burst_addr_r <= burst_addr_r + (ASIZE'(burst_len_r) * ASIZE'(BYTES_PER_BEAT_C));
      end
    end
  end

  assign bus.burst_req  = burst_req_r;
  assign bus.burst_len  = burst_len_r;
  assign bus.burst_addr = burst_addr_r;
  assign bus.burst_tail = burst_tail_r;
  assign frame_done     = frame_done_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_write_burst_scheduler.sv
// Bench: a ONCE-mode and a LINE-mode scheduler share frame inputs; each has
// its own randomized AXI master responder. Expected bursts come from a
// frame-level reference model and are checked by a separate monitor.
module tb_write_burst_scheduler;

  localparam int NOR = 4;
  localparam int DSZ = 24;
  localparam int AXW = 256;

  typedef struct {
    logic [8:0]  len;
    logic [31:0] addr;
    logic        tail;
  } burst_t;

  logic        clock;
  logic        rst;
  logic [15:0] hactive, vactive, fifo_count;
  logic [31:0] base_addr;
  logic        fsync;
  logic [1:0]  fd_v, busy_v, req_v, ack_v, done_v, ack_s, req_p;
  logic [41:0] cur_v [2];

  int     checks = 0;
  int     errors = 0;
  burst_t q0[$];
  burst_t q1[$];
  int     fd_exp [2];
  int     acks_seen [2];
  int     rsp_st [2];
  int     rsp_dly [2];
  int     ack_min = 0, ack_max = 3;
  logic   ack_hold = 1'b0, done_hold = 1'b0;

  write_burst_scheduler_if #(.LSIZE(9), .ASIZE(32)) bus_o ();
  write_burst_scheduler_if #(.LSIZE(9), .ASIZE(32)) bus_l ();

  assign bus_o.burst_ack  = ack_v[0];
  assign bus_o.burst_done = done_v[0];
  assign bus_l.burst_ack  = ack_v[1];
  assign bus_l.burst_done = done_v[1];
  assign req_v[0] = bus_o.burst_req;
  assign req_v[1] = bus_l.burst_req;

  write_burst_scheduler #(.NOR_BURST_LEN(NOR), .MODE("ONCE"), .AXI_DSIZE(AXW),
    .DSIZE(DSZ), .LSIZE(9), .ASIZE(32)) dut_once (
    .clock(clock), .rst(rst), .vactive(vactive), .hactive(hactive),
    .base_addr(base_addr), .fsync(fsync), .fifo_count(fifo_count),
    .bus(bus_o), .frame_done(fd_v[0]), .busy(busy_v[0]));

  write_burst_scheduler #(.NOR_BURST_LEN(NOR), .MODE("LINE"), .AXI_DSIZE(AXW),
    .DSIZE(DSZ), .LSIZE(9), .ASIZE(32)) dut_line (
    .clock(clock), .rst(rst), .vactive(vactive), .hactive(hactive),
    .base_addr(base_addr), .fsync(fsync), .fifo_count(fifo_count),
    .bus(bus_l), .frame_done(fd_v[1]), .busy(busy_v[1]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] bus_word(input int i);
    if (i == 0) return {bus_o.burst_len, bus_o.burst_addr, bus_o.burst_tail};
    return {bus_l.burst_len, bus_l.burst_addr, bus_l.burst_tail};
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void push_exp(input int i, input int len, input logic [31:0] addr, input logic tail);
    burst_t e;
    e.len = 9'(len); e.addr = addr; e.tail = tail;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  // Reference model: mode 0 = ONCE, mode 1 = LINE.
  function automatic void push_frame(input int h, input int v, input logic [31:0] base);
    for (int m = 0; m < 2; m++) begin
      int unsigned pix, beats, nx, left, take;
      logic [31:0] a;
      nx    = (m == 1) ? v : 1;
      pix   = (m == 1) ? h : h * v;
      beats = (pix * DSZ + AXW - 1) / AXW;
      a     = base;
      if (beats != 0 && nx != 0) begin
        for (int t = 0; t < int'(nx); t++) begin
          left = beats;
          while (left > 0) begin
            take = (left > NOR) ? NOR : left;
            left = left - take;
            push_exp(m, int'(take), a, (left == 0));
            a = a + take * (AXW / 8);
          end
        end
      end
      fd_exp[m]++;
    end
  endfunction

  task automatic pulse_fsync();
    @(negedge clock); fsync = 1'b1;
    @(negedge clock); fsync = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (q0.size() == 0 && q1.size() == 0 && fd_exp[0] == 0 && fd_exp[1] == 0 && busy_v == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_complete", 64'(ok), 64'd1);
    if (!ok) begin
      q0.delete(); q1.delete(); fd_exp[0] = 0; fd_exp[1] = 0;
      @(negedge clock); rst = 1'b1;
      @(negedge clock); rst = 1'b0;
    end
  endtask

  task automatic run_frame(input int h, input int v, input logic [31:0] base);
    hactive = 16'(h); vactive = 16'(v); base_addr = base;
    push_frame(h, v, base);
    pulse_fsync();
    wait_idle(4000);
  endtask

  // AXI master responder: random ack latency, random done latency, stray done pulses
  initial begin
    ack_v = 2'b00; done_v = 2'b00;
    rsp_st[0] = 0; rsp_st[1] = 0; rsp_dly[0] = 0; rsp_dly[1] = 0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        ack_v[i] = 1'b0; done_v[i] = 1'b0;
        if (rst) begin
          rsp_st[i] = 0;
        end else begin
          case (rsp_st[i])
            0: if (req_v[i]) begin
                 rsp_st[i] = 1; rsp_dly[i] = $urandom_range(ack_max, ack_min);
               end else begin
                 done_v[i] = ($urandom_range(7, 0) == 0);
               end
            2: if (!done_hold) begin
                 if (rsp_dly[i] == 0) begin done_v[i] = 1'b1; rsp_st[i] = 0; end
                 else rsp_dly[i]--;
               end
            default: ;
          endcase
          if (rsp_st[i] == 1 && !ack_hold) begin
            if (rsp_dly[i] == 0) begin
              ack_v[i] = 1'b1; done_v[i] = 1'($urandom_range(1, 0));
              rsp_st[i] = 2; rsp_dly[i] = $urandom_range(3, 0);
            end else begin
              rsp_dly[i]--;
            end
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each new command and on each frame_done
  initial begin
    req_p = 2'b00;
    acks_seen[0] = 0; acks_seen[1] = 0;
    forever begin
      @(posedge clock);
      ack_s = ack_v;
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (ack_s[i] && !rst) begin
          acks_seen[i]++;
          chk($sformatf("req_drop_after_ack_d%0d", i), 64'(req_v[i]), 64'd0);
        end else if (req_v[i] && !req_p[i]) begin
          chk($sformatf("burst_expected_d%0d", i), 64'(qsize(i) > 0), 64'd1);
          if (qsize(i) > 0) begin
            burst_t e;
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("burst_len_addr_tail_d%0d", i), 64'(bus_word(i)), 64'({e.len, e.addr, e.tail}));
          end
          cur_v[i] = bus_word(i);
        end else if (req_v[i]) begin
          chk($sformatf("burst_stable_d%0d", i), 64'(bus_word(i)), 64'(cur_v[i]));
        end
        if (fd_v[i]) begin
          chk($sformatf("frame_done_expected_d%0d", i), 64'(fd_exp[i] > 0), 64'd1);
          chk($sformatf("bursts_before_done_d%0d", i), 64'(qsize(i)), 64'd0);
          if (fd_exp[i] > 0) fd_exp[i]--;
        end
        req_p[i] = req_v[i];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    logic ok;
    fd_exp[0] = 0; fd_exp[1] = 0;
    rst = 1'b1; fsync = 1'b0; hactive = 16'd0; vactive = 16'd0;
    base_addr = 32'h1000; fifo_count = 16'd100;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_outputs_d%0d", i), 64'({req_v[i], bus_word(i), fd_v[i], busy_v[i]}), 64'd0);
    rst = 1'b0;

    // Directed frames
    run_frame(64, 1, 32'h1000);
    run_frame(128, 1, 32'h1000);
    run_frame(64, 3, 32'h1000);
    run_frame(10, 1, 32'h1000);
    run_frame(0, 1, 32'h1000);
    run_frame(64, 0, 32'h1000);

    // FIFO stall, restart from WAIT_DATA, then a held ack
    fifo_count = 16'd3; hactive = 16'd64; vactive = 16'd1; base_addr = 32'h1000;
    push_frame(64, 1, 32'h1000);
    pulse_fsync();
    repeat (8) @(negedge clock);
    chk("stall_no_req", 64'(req_v), 64'd0);
    pulse_fsync();
    repeat (4) @(negedge clock);
    chk("stall_after_restart_no_req", 64'(req_v), 64'd0);
    ack_min = 5; ack_max = 5; fifo_count = 16'd4;
    wait_idle(2000);
    ack_min = 0; ack_max = 3; fifo_count = 16'd100;

    // fsync while WAIT_DONE: burst completes, new frame restarts at the new base
    done_hold = 1'b1; hactive = 16'd64; vactive = 16'd1; base_addr = 32'h1000;
    a0 = acks_seen[0]; a1 = acks_seen[1];
    push_exp(0, 4, 32'h1000, 1'b0);
    push_exp(1, 4, 32'h1000, 1'b0);
    pulse_fsync();
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (acks_seen[0] > a0 && acks_seen[1] > a1) begin ok = 1'b1; break; end
    end
    chk("first_ack_seen", 64'(ok), 64'd1);
    base_addr = 32'h2000;
    push_frame(64, 1, 32'h2000);
    pulse_fsync();
    repeat (3) @(negedge clock);
    done_hold = 1'b0;
    wait_idle(2000);

    // Reset while a command is held in REQ
    ack_hold = 1'b1; hactive = 16'd128; vactive = 16'd1; base_addr = 32'h3000;
    push_exp(0, 4, 32'h3000, 1'b0);
    push_exp(1, 4, 32'h3000, 1'b0);
    pulse_fsync();
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (req_v == 2'b11) begin ok = 1'b1; break; end
    end
    chk("req_reached", 64'(ok), 64'd1);
    rst = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 2; i++)
      chk($sformatf("midburst_reset_outputs_d%0d", i), 64'({req_v[i], bus_word(i), fd_v[i], busy_v[i]}), 64'd0);
    rst = 1'b0; ack_hold = 1'b0;
    repeat (10) @(negedge clock);
    chk("idle_after_reset", 64'(busy_v), 64'd0);

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      fifo_count = 16'($urandom_range(100, NOR));
      ack_max = $urandom_range(4, 0);
      run_frame($urandom_range(200, 0), $urandom_range(4, 0),
                32'h1000 + 32'($urandom_range(255, 0)) * 32'd32);
    end

    chk("leftover_bursts_d0", 64'(q0.size()), 64'd0);
    chk("leftover_bursts_d1", 64'(q1.size()), 64'd0);
    chk("leftover_frames", 64'(fd_exp[0] + fd_exp[1]), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
